// File: rtl/m_mem_access_ctrl.sv
// M-stage load/store initiator: checks alignment/range, issues one word request over req/ack,
// returns extended load data. Optional store trace is enabled by defining MEM_TRACE_EN.
module m_mem_access_ctrl #(
  parameter logic [31:0] ADDR_LIMIT     = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OpLw  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLhu = 4'd3;
  localparam logic [3:0] OpLb  = 4'd4;
  localparam logic [3:0] OpLbu = 4'd5;
  localparam logic [3:0] OpSw  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSb  = 4'd8;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      op_q;
  logic [1:0]      lo_q;

  logic        is_load, is_store, misaligned, in_range, issue;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_load    = (mem_op >= OpLw) && (mem_op <= OpLbu);
    is_store   = (mem_op >= OpSw) && (mem_op <= OpSb);
    misaligned = 1'b0;
    unique case (mem_op)
      OpLw, OpSw:        misaligned = (addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: misaligned = addr[0];
      default:           misaligned = 1'b0;
    endcase
    in_range = (addr < ADDR_LIMIT);
    issue    = (state_q == StIdle) && op_valid && (is_load || is_store) && !misaligned && in_range;
    adel     = (state_q == StIdle) && op_valid && is_load && (misaligned || !in_range);
    ades     = (state_q == StIdle) && op_valid && is_store && (misaligned || !in_range);
    stall    = issue || (state_q == StReq);
  end

  // Store lane steering; loads always read the full word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    unique case (mem_op)
      OpSw: wdata_d = wdata;
      OpSh: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      OpSb: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_sel  = bus_rdata[{lo_q, 3'b000} +: 8];
    half_sel  = bus_rdata[{lo_q[1], 4'b0000} +: 16];
    load_data = 32'h0;
    unique case (op_q)
      OpLw:    load_data = bus_rdata;
      OpLh:    load_data = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_data = {16'h0, half_sel};
      OpLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_data = {24'h0, byte_sel};
      default: load_data = 32'h0;
    endcase
  end

`ifdef MEM_TRACE_EN
  logic [31:0] pc_q;
  logic [31:0] be_mask;
  assign be_mask = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'h0;
    end else if (issue) begin
      pc_q <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == StReq) && bus_ack && bus_we) begin
      $display("%d@%08h: *%08h <= %08h", $time, pc_q, bus_addr, bus_wdata & be_mask);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= 4'h0;
      lo_q        <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= 4'h0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q   <= StReq;
            cnt_q     <= '0;
            op_q      <= mem_op;
            lo_q      <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_be    <= be_d;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= wdata_d;
          end
        end
        StReq: begin
          if (bus_ack) begin
            state_q     <= StDone;
            bus_req     <= 1'b0;
            rdata       <= load_data;
            rdata_valid <= 1'b1;
          end else if (cnt_q == CntMax) begin
            state_q     <= StDone;
            bus_req     <= 1'b0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b1;
            bus_err     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_access_ctrl.sv
// Bench for m_mem_access_ctrl: directed vector table, reset/timeout sequences and randomized ops
// checked against an arithmetic reference model.
module tb_m_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata, pc;
  logic        stall, rdata_valid, adel, ades, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  m_mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .pc         (pc),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .adel       (adel),
    .ades       (ades),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 no-op, 1 legal, 2 adel, 3 ades
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, wd, rd;
    int          dly;
    int          kind;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    bit          chkwd;
    logic [31:0] erd;
    bit          eerr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model, straight from the op rules.
  function automatic bit m_load(input logic [3:0] op);
    return op >= 1 && op <= 5;
  endfunction
  function automatic bit m_store(input logic [3:0] op);
    return op >= 6 && op <= 8;
  endfunction
  function automatic int m_kind(input logic [3:0] op, input logic [31:0] a);
    int sz;
    if (!m_load(op) && !m_store(op)) return 0;
    sz = (op == 1 || op == 6) ? 4 : (op == 2 || op == 3 || op == 7) ? 2 : 1;
    if ((a % sz) != 0 || a >= 32'h3000) return m_load(op) ? 2 : 3;
    return 1;
  endfunction
  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    if (op == 7) return (a % 4 >= 2) ? 4'hC : 4'h3;
    if (op == 8) return 4'(1 << (a % 4));
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] wd);
    if (op == 7) return (wd & 32'hFFFF) * 32'h0001_0001;
    if (op == 8) return (wd & 32'hFF) * 32'h0101_0101;
    return wd;
  endfunction
  function automatic logic [31:0] m_rd(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] rd, input int dly);
    int v;
    if (!m_load(op) || dly >= TO) return 32'h0;
    if (op == 1) return rd;
    if (op == 2 || op == 3) begin
      v = int'((rd >> (16 * ((a % 4) / 2))) & 32'hFFFF);
      if (op == 2 && v >= 32768) v = v - 65536;
    end else begin
      v = int'((rd >> (8 * (a % 4))) & 32'hFF);
      if (op == 4 && v >= 128) v = v - 256;
    end
    return 32'(v);
  endfunction

  task automatic run_op(input vec_t v);
    int nreq;
    @(negedge clk);
    op_valid = 1'b1; mem_op = v.op; addr = v.a; wdata = v.wd; bus_ack = 1'b0; bus_rdata = v.rd;
    pc = $urandom;
    #1;
    check("adel", 32'(adel), 32'(v.kind == 2));
    check("ades", 32'(ades), 32'(v.kind == 3));
    check("stall_issue", 32'(stall), 32'(v.kind == 1));
    if (v.kind != 1) begin
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check("no_req", 32'(bus_req), 32'h0);
      check("no_valid", 32'(rdata_valid), 32'h0);
      return;
    end
    nreq = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      bus_ack = (k == v.dly);
      #1;
      if (k == 0) begin
        check("bus_we", 32'(bus_we), 32'(m_store(v.op)));
        check("bus_be", 32'(bus_be), 32'(v.ebe));
        check("bus_addr", bus_addr, v.a & 32'hFFFF_FFFC);
        if (v.chkwd) check("bus_wdata", bus_wdata, v.ewd);
      end
      if (bus_req && stall) nreq++;
      if (k == v.dly) break;
    end
    check("req_cycles", 32'(nreq), 32'((v.dly < TO) ? v.dly + 1 : TO));
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rdata_valid", 32'(rdata_valid), 32'h1);
    check("rdata", rdata, v.erd);
    check("bus_err", 32'(bus_err), 32'(v.eerr));
    check("stall_done", 32'(stall), 32'h0);
    check("req_done", 32'(bus_req), 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("valid_pulse", 32'(rdata_valid), 32'h0);
    check("err_pulse", 32'(bus_err), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0]  = '{4'd6, 32'h10,   32'hDEADBEEF, 32'h0,         0,  1, 4'hF, 32'hDEADBEEF, 1, 32'h0, 0};
    vecs[1]  = '{4'd8, 32'h13,   32'h000000A5, 32'h0,         0,  1, 4'h8, 32'hA5A5A5A5, 1, 32'h0, 0};
    vecs[2]  = '{4'd4, 32'h13,   32'h0,        32'h80FF0000,  0,  1, 4'hF, 32'h0, 0, 32'hFFFFFF80, 0};
    vecs[3]  = '{4'd5, 32'h13,   32'h0,        32'h80FF0000,  1,  1, 4'hF, 32'h0, 0, 32'h00000080, 0};
    vecs[4]  = '{4'd2, 32'h22,   32'h0,        32'h80011234,  0,  1, 4'hF, 32'h0, 0, 32'hFFFF8001, 0};
    vecs[5]  = '{4'd3, 32'h22,   32'h0,        32'h80011234,  2,  1, 4'hF, 32'h0, 0, 32'h00008001, 0};
    vecs[6]  = '{4'd1, 32'h21,   32'h0,        32'h0,         0,  2, 4'hF, 32'h0, 0, 32'h0, 0};
    vecs[7]  = '{4'd6, 32'h3000, 32'h12345678, 32'h0,         0,  3, 4'hF, 32'h0, 0, 32'h0, 0};
    vecs[8]  = '{4'd1, 32'h40,   32'h0,        32'h12345678, 99,  1, 4'hF, 32'h0, 0, 32'h0, 1};
    vecs[9]  = '{4'd7, 32'h16,   32'h1234ABCD, 32'h0,         0,  1, 4'hC, 32'hABCDABCD, 1, 32'h0, 0};
    vecs[10] = '{4'd1, 32'h2FFC, 32'h0,        32'hCAFEF00D,  3,  1, 4'hF, 32'h0, 0, 32'hCAFEF00D, 0};
    vecs[11] = '{4'd7, 32'h11,   32'h0,        32'h0,         0,  3, 4'hF, 32'h0, 0, 32'h0, 0};
    vecs[12] = '{4'd5, 32'h2FFF, 32'h0,        32'hAB000000, 15,  1, 4'hF, 32'h0, 0, 32'h000000AB, 0};

    reset = 1'b1; op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_req", 32'(bus_req), 32'h0);
    check("rst_we_be", {27'h0, bus_we, bus_be}, 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {29'h0, rdata_valid, bus_err, adel | ades}, 32'h0);

    // Stray ack while idle must not complete anything.
    @(negedge clk); bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0; #1;
    check("idle_ack", {30'h0, rdata_valid, bus_req}, 32'h0);

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // Reset during the second REQ cycle abandons the transaction.
    @(negedge clk);
    op_valid = 1'b1; mem_op = 4'd1; addr = 32'h100; bus_ack = 1'b0;
    @(negedge clk); #1;
    check("mid_req1", 32'(bus_req), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'h0);
    check("mid_rst_valid", 32'(rdata_valid), 32'h0);
    @(negedge clk); #1;
    check("mid_rst_valid2", 32'(rdata_valid), 32'h0);
    rv = '{4'd1, 32'h104, 32'h0, 32'h55AA00FF, 0, 1, 4'hF, 32'h0, 0, 32'h55AA00FF, 0};
    run_op(rv);

    for (int i = 0; i < 80; i++) begin
      rv.op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       rv.a = 32'h3000 + $urandom_range(0, 255);
        1:       rv.a = 32'h2FF8 + $urandom_range(0, 7);
        default: rv.a = $urandom_range(0, 32'h2FFF);
      endcase
      rv.wd    = $urandom;
      rv.rd    = $urandom;
      rv.dly   = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
      rv.kind  = m_kind(rv.op, rv.a);
      rv.ebe   = m_be(rv.op, rv.a);
      rv.ewd   = m_wd(rv.op, rv.wd);
      rv.chkwd = m_store(rv.op);
      rv.erd   = m_rd(rv.op, rv.a, rv.rd, rv.dly);
      rv.eerr  = (rv.dly >= TO);
      run_op(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_mem_access_ctrl.md
Name: m_mem_access_ctrl

Overview:
M-stage load/store initiator for the P6 pipeline. It takes one memory instruction per accepted operation, checks alignment and range, and issues a single word-wide request with byte enables to the data-memory responder over a req/ack handshake. It then returns sign- or zero-extended load data to the pipeline. It stalls the pipeline while a transaction is outstanding.

Parameters:
ADDR_LIMIT, 32'h0000_3000, first illegal byte address (12 KB data space); addr >= limit raises an error
TIMEOUT_CYCLES, 16, max cycles in REQ without bus_ack before bus error

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
op_valid  input  1  M-stage holds a memory op this cycle
mem_op  input  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as NONE
addr  input  32  byte address
wdata  input  32  store data (low bits used for SB/SH)
pc  input  32  PC of the M-stage instruction (trace only)
stall  output  1  freeze F/D/E/M
rdata  output  32  extended load result
rdata_valid  output  1  one-cycle pulse, op complete
adel  output  1  load address error (misaligned or out of range)
ades  output  1  store address error
bus_err  output  1  one-cycle pulse, timeout
bus_req  output  1  request to DM
bus_we  output  1  1 = write
bus_be  output  4  byte enables
bus_addr  output  32  word address {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  responder completes request this cycle
bus_rdata  input  32  read word, valid with bus_ack

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- State on reset: state=IDLE.
- Output values on reset: every registered output 0 (bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, rdata_valid, bus_err).
- Reset mid-transaction: the transaction is abandoned; bus_req drops at that edge; no rdata_valid is produced.
- States: IDLE, REQ, DONE.
- IDLE, valid legal op: op_valid=1, op != NONE, aligned (LW/SW addr[1:0]=0; LH/LHU/SH addr[0]=0), addr < ADDR_LIMIT. Latch bus_addr/we/be/wdata, go to REQ. stall=1 combinationally this cycle.
- IDLE, illegal op: adel (loads) or ades (stores) asserted combinationally. stall=0, no bus transaction, stay IDLE.
- REQ: bus_req=1 held stable. stall=1. Timeout counter increments each cycle.
  - bus_ack=1: capture bus_rdata, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with bus_err=1 and rdata=0.
- DONE: stall=0. rdata_valid=1 for all ops; rdata is meaningful for loads only and is 0 for stores. Always returns to IDLE.
- Latency: minimum 2 stall cycles (ack in first REQ cycle), so the op spends 3 cycles in M.
- Stores:
  - SW: be=4'b1111, bus_wdata=wdata.
  - SH: be=addr[1]?4'b1100:4'b0011, bus_wdata={2{wdata[15:0]}}.
  - SB: be=4'b0001<<addr[1:0], bus_wdata={4{wdata[7:0]}}.
- Loads:
  - Loads assert be=4'b1111 and bus_we=0.
  - Extraction uses the latched addr[1:0]: byte lane addr[1:0], halfword lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- bus_ack outside REQ is ignored.
- op_valid/mem_op changes while in REQ/DONE are ignored; the pipeline holds M during stall.

Optional Feature:
MEM_TRACE_EN:
- When defined, each store completing in REQ with bus_ack prints via $display: "%d@%08h: *%08h <= %08h" using $time, latched pc, bus_addr and the merged write word. The merged word is wdata placed in its lane, with non-enabled bytes shown as 0.
- When undefined, no display statements are compiled and behaviour is otherwise identical.

Test Plan:
- reset held 2 cycles then released -> all outputs 0, stall=0, state IDLE.
- SW addr=0x10 wdata=0xDEADBEEF, ack on first REQ cycle -> bus_we=1, be=1111, bus_addr=0x10, stall high 2 cycles, rdata_valid pulse in cycle 3.
- SB addr=0x13 wdata=0x000000A5 -> be=1000, bus_wdata=0xA5A5A5A5. LB same addr with bus_rdata=0x80FF0000 -> rdata=0xFFFFFF80; LBU -> 0x00000080.
- LH addr=0x22, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001; LHU -> 0x00008001; LW addr=0x21 -> adel=1, stall=0, bus_req never asserted.
- SW addr=0x3000 -> ades=1, no request. LW with bus_ack held low -> bus_req high for 16 cycles, then bus_err pulse, rdata=0, rdata_valid pulse.
- reset asserted in second REQ cycle -> bus_req 0 after that edge, no rdata_valid, next LW completes normally.
